// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared FSM state and radix-4 digit encodings for booth_seq_mult
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } digit_t;

endpackage

// File: rtl/booth_recoder.sv
// rtl/booth_recoder.sv - maps a Booth triplet {b[2j+1], b[2j], b[2j-1]} to a radix-4 digit
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet_i,
    output logic [2:0] digit_o
);

    digit_t digit;

    always_comb begin
        digit = ZERO;
        case (triplet_i)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

    assign digit_o = digit;

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per cycle
// Optional BOOTH_EARLY_EXIT_EN: leave CALC as soon as all remaining digits are zero.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy
);

    localparam int AW = 2 * N + 2;
    localparam int BW = N + 3;
    localparam int CW = $clog2(N / 2 + 1) + 1;
    localparam logic [CW-1:0] LAST = CW'(N / 2);

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  prod_q, prod_d;

    logic [2:0]      digit_w;
    digit_t          digit;
    logic [AW-1:0]   mag;
    logic [AW-1:0]   addend;
    logic [BW-1:0]   b_shift;
    logic            last_digit;
    logic            accept;

    // b_q holds {b_ext, b[-1]}; the low three bits are always the current triplet.
    booth_recoder u_recoder (
        .triplet_i (b_q[2:0]),
        .digit_o   (digit_w)
    );

    assign digit   = digit_t'(digit_w);
    assign b_shift = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
    assign accept  = in_valid & in_ready;

    always_comb begin
        mag = '0;
        case (digit)
            P1:      mag = a_q;
            P2:      mag = a_q << 1;
            M1:      mag = -a_q;
            M2:      mag = -(a_q << 1);
            default: mag = '0;
        endcase
        addend = mag << {cnt_q, 1'b0};
    end

    // Remaining digits are all zero exactly when the shifted multiplier is all-0s or all-1s.
    always_comb begin
`ifdef BOOTH_EARLY_EXIT_EN
        last_digit = (cnt_q == LAST) || (b_shift == '0) || (b_shift == '1);
`else
        last_digit = (cnt_q == LAST);
`endif
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC);

        case (state_q)
            IDLE: ;
            CALC: begin
                acc_d = acc_q + addend;
                b_d   = b_shift;
                cnt_d = cnt_q + CW'(1);
                if (last_digit) begin
                    state_d = DONE;
                    prod_d  = acc_d[2*N-1:0];
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = signed_mode ? {{(N+2){a[N-1]}}, a} : {{(N+2){1'b0}}, a};
            b_d     = {{2{signed_mode & b[N-1]}}, b, 1'b0};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - scoreboard bench for booth_seq_mult against an arithmetic reference
module tb_booth_seq_mult;

    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     a = '0;
    logic [N-1:0]     b = '0;
    logic             signed_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*N-1:0]   product;
    logic             busy;

    booth_seq_mult #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [2*N-1:0] expq[$];
    int             latq[$];
    int             accq[$];

    bit             ordy_rand = 0;
    bit             ordy_fix  = 1;
    bit             seen      = 0;
    bit             hold_prev = 0;
    logic [2*N-1:0] hold_val  = '0;
    bit             b2b_chk   = 0;
    bit             have_last = 0;
    int             last_acc  = 0;
    int             last_lat  = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y, input bit m);
        longint sx, sy, p;
        sx = m ? longint'($signed(x)) : longint'(x);
        sy = m ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        return p[2*N-1:0];
    endfunction

    function automatic int bitv(input logic [N-1:0] y, input bit m, input int k);
        if (k < 0) return 0;
        if (k < N) return int'(y[k]);
        return m ? int'(y[N-1]) : 0;
    endfunction

    // Cycles from accept to first out_valid.
    function automatic int ref_lat(input logic [N-1:0] y, input bit m);
        int last_nz;
        int d;
        last_nz = 0;
        for (int j = 0; j <= N / 2; j++) begin
            d = -2 * bitv(y, m, 2*j+1) + bitv(y, m, 2*j) + bitv(y, m, 2*j-1);
            if (d != 0) last_nz = j;
        end
`ifdef BOOTH_EARLY_EXIT_EN
        return last_nz + 1;
`else
        return (last_nz >= 0) ? N / 2 + 1 : N / 2 + 1;
`endif
    endfunction

    task automatic tick(input bit iv, input logic [N-1:0] av, input logic [N-1:0] bv, input bit mv);
        @(negedge clk);
        in_valid    = iv;
        a           = av;
        b           = bv;
        signed_mode = mv;
        out_ready   = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_fix;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, '0, 0);
    endtask

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input bit mv, input logic [2*N-1:0] exp);
        bit done;
        int acc;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            tick(1, av, bv, mv);
            if (in_ready) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: operands a=0x%0h b=0x%0h never accepted", av, bv);
        end else begin
            acc = cyc + 1;
            expq.push_back(exp);
            latq.push_back(ref_lat(bv, mv));
            accq.push_back(acc);
            if (b2b_chk && have_last) chk("b2b_gap", 64'(acc - last_acc), 64'(last_lat + 1));
            have_last = 1;
            last_acc  = acc;
            last_lat  = ref_lat(bv, mv);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_product", 64'(product), 64'(hold_val));
            end
            if (out_valid && !seen) begin
                seen = 1;
                if (latq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out: product 0x%0h with nothing outstanding", product);
                end else begin
                    chk("latency", 64'(cyc - accq.pop_front()), 64'(latq.pop_front()));
                end
            end
            if (out_valid && out_ready) begin
                if (expq.size() != 0) chk("product", 64'(product), 64'(expq.pop_front()));
                seen = 0;
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = product;
        end
    end

    initial begin
        logic [N-1:0] ra, rb;
        bit           rm;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        send(8'hFF, 8'hFF, 0, 16'hFE01);
        idle(8);
        send(8'h80, 8'h80, 1, 16'h4000);
        idle(8);
        send(8'hFF, 8'h05, 1, 16'hFFFB);
        idle(8);
        send(8'hFF, 8'h05, 0, 16'h04FB);
        idle(8);
        send(8'h5A, 8'h00, 0, 16'h0000);
        idle(8);
        send(8'h5A, 8'h03, 0, 16'h010E);
        idle(8);

        ordy_fix = 0;
        send(8'h9C, 8'h37, 1, ref_prod(8'h9C, 8'h37, 1));
        idle(16);
        ordy_fix = 1;
        idle(1);
        idle(1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_busy", 64'(busy), 64'd0);

        b2b_chk   = 1;
        have_last = 0;
        for (int i = 0; i < 6; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rm = 1'($urandom);
            send(ra, rb, rm, ref_prod(ra, rb, rm));
        end
        b2b_chk = 0;
        idle(10);

        send(8'h7B, 8'hC3, 1, ref_prod(8'h7B, 8'hC3, 1));
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("busy_in_calc", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_product", 64'(product), 64'd0);
        expq.delete();
        latq.delete();
        accq.delete();
        seen      = 0;
        hold_prev = 0;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        send(8'hFF, 8'h05, 1, 16'hFFFB);
        idle(8);

        ordy_rand = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = '0;
                1:       ra = '1;
                2:       ra = {1'b1, {(N-1){1'b0}}};
                default: ra = N'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = {1'b1, {(N-1){1'b0}}};
                default: rb = N'($urandom);
            endcase
            rm = 1'($urandom);
            send(ra, rb, rm, ref_prod(ra, rb, rm));
            idle($urandom_range(0, 2));
        end

        ordy_rand = 0;
        ordy_fix  = 1;
        for (int t = 0; t < 100 && expq.size() != 0; t++) idle(1);
        chk("drain_outstanding", 64'(expq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter N, default 8: operand width; even, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands a, b and signed_mode are valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  N  multiplicand.
REQ-007 SHALL have port b  input  N  multiplier.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  product is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes product this cycle.
REQ-011 SHALL have port product  output  2N  full-width result.
REQ-012 SHALL have port busy  output  1  high in CALC.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-015 SHALL accept operands on a rising edge with in_valid & in_ready: latch a, b and mode, clear accumulator, clear digit counter, enter CALC.
REQ-016 SHALL extend a and b to N+2 bits per the latched mode (sign-extend if signed, zero-extend if unsigned), with an implicit b[-1] = 0.
REQ-017 SHALL, in CALC, retire one radix-4 digit per cycle: recode triplet {b[2j+1], b[2j], b[2j-1]} to 0, +A, +2A, -A or -2A; add digit*A << 2j into a 2N+2-bit accumulator.
REQ-018 SHALL process exactly N/2+1 digits in both modes; the last digit SHALL be zero in signed mode.
REQ-019 SHALL enter DONE after the last digit; the first out_valid cycle is N/2+1 cycles after the accept cycle (N=8: 5).
REQ-020 SHALL hold product and out_valid stable in DONE until out_ready is high.
REQ-021 SHALL, on DONE & out_ready & in_valid, accept new operands in the same cycle and enter CALC (back-to-back, no bubble).
REQ-022 SHALL, on DONE & out_ready & !in_valid, go to IDLE.
REQ-023 SHALL ignore in_valid in CALC; operand inputs are don't-care there.
REQ-024 SHALL drive product = accumulator[2N-1:0], which is exact for all operand values in both modes.
REQ-025 SHALL hold out_valid low outside DONE; product SHALL keep its last value outside DONE.

Reset
REQ-026 SHALL, on rst, force state IDLE and clear accumulator, counter, latched operands and product, regardless of current state (mid-CALC aborts without producing output).
REQ-027 SHALL reset outputs to: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, product=0.

Configuration
REQ-028 SHALL honour macro BOOTH_EARLY_EXIT_EN: when defined, CALC SHALL enter DONE on the next edge once all remaining recoded digits are zero, so latency varies from 1 to N/2+1 cycles; when undefined, latency is fixed at N/2+1 cycles.
REQ-029 SHALL produce identical product values with and without BOOTH_EARLY_EXIT_EN.

Structure
REQ-030 SHALL take the FSM state enum and the recoded-digit encoding (ZERO, P1, P2, M1, M2) from shared package booth_pkg.
REQ-031 SHALL instantiate one combinational sub-module, booth_recoder, which maps a 3-bit triplet to a digit encoding.

Verification
REQ-032 Unsigned, N=8, a=255, b=255 -> product=0xFE01; out_valid rises 5 cycles after accept (macro undefined).
REQ-033 Signed, a=0x80, b=0x80 -> 0x4000; signed a=0xFF, b=0x05 -> 0xFFFB; unsigned with the same operands -> 0x04FB.
REQ-034 out_ready held low for 10 cycles in DONE -> product and out_valid stable; release -> IDLE the next cycle.
REQ-035 Back-to-back: in_valid constant with out_ready=1 -> one product every 6 cycles, no IDLE cycle.
REQ-036 rst asserted on the 3rd CALC cycle -> all outputs at reset values immediately; next operands give a correct result.
REQ-037 BOOTH_EARLY_EXIT_EN defined, b=0 -> out_valid 1 cycle after accept, product=0; b=0x03 -> latency 2, product=3*a.
